// File: rtl/async_fifo_gray_if.sv
// Producer/consumer signal bundle for async_fifo_gray. The write-side group is
// clk_1 synchronous, the read-side group is clk_2 synchronous.
interface async_fifo_gray_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned DEPTH  = 8
);
    localparam int unsigned ADDR_W = $clog2(DEPTH);

    logic              data_1_en;
    logic [DATA_W-1:0] data_1;
    logic              buffer_full;
    logic              almost_full;
    logic [ADDR_W:0]   wr_level;
    logic              overflow;

    logic              data_2_rd;
    logic [DATA_W-1:0] data_2;
    logic              data_2_valid;
    logic              buffer_empty;
    logic              almost_empty;
    logic [ADDR_W:0]   rd_level;
    logic              underflow;

    modport master (
        output data_1_en, data_1, data_2_rd,
        input  buffer_full, almost_full, wr_level, overflow,
        input  data_2, data_2_valid, buffer_empty, almost_empty, rd_level, underflow
    );

    modport slave (
        input  data_1_en, data_1, data_2_rd,
        output buffer_full, almost_full, wr_level, overflow,
        output data_2, data_2_valid, buffer_empty, almost_empty, rd_level, underflow
    );
endinterface

// File: rtl/async_fifo_gray.sv
// Dual-clock FIFO from clk_1 (writer) to clk_2 (reader). Gray pointers cross through
// two-flop synchronisers; all status outputs are registered.
module async_fifo_gray #(
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned DEPTH    = 8,
    parameter int unsigned AF_LEVEL = DEPTH - 2,
    parameter int unsigned AE_LEVEL = 2
) (
    input  logic             clk_1,
    input  logic             clk_2,
    input  logic             rst,
    async_fifo_gray_if.slave bus
);
    localparam int unsigned ADDR_W = $clog2(DEPTH);
    localparam logic [ADDR_W:0] AF_THR = (ADDR_W + 1)'(AF_LEVEL);
    localparam logic [ADDR_W:0] AE_THR = (ADDR_W + 1)'(AE_LEVEL);

    function automatic logic [ADDR_W:0] bin2gray(input logic [ADDR_W:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [ADDR_W:0] gray2bin(input logic [ADDR_W:0] g);
        logic [ADDR_W:0] b;
        b[ADDR_W] = g[ADDR_W];
        for (int i = int'(ADDR_W) - 1; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    logic [DATA_W-1:0] mem [DEPTH];

    // Assertion is immediate via the async set; release is delayed two edges per domain.
    logic [1:0] rst_1_q, rst_2_q;
    logic       rst_w, rst_r;

    always_ff @(posedge clk_1 or posedge rst) begin
        if (rst) rst_1_q <= 2'b11;
        else     rst_1_q <= {rst_1_q[0], 1'b0};
    end

    always_ff @(posedge clk_2 or posedge rst) begin
        if (rst) rst_2_q <= 2'b11;
        else     rst_2_q <= {rst_2_q[0], 1'b0};
    end

    assign rst_w = rst_1_q[1];
    assign rst_r = rst_2_q[1];

    // Write domain
    logic [ADDR_W:0] wbin_q, wbin_d, wgray_q, wgray_d;
    logic [ADDR_W:0] rgray_s1_q, rgray_s2_q;
    logic [ADDR_W:0] wr_level_q, wr_level_d;
    logic            full_q, full_d, af_q, af_d, ovf_q, wr_acc;

    // Read domain
    logic [ADDR_W:0]   rbin_q, rbin_d, rgray_q, rgray_d;
    logic [ADDR_W:0]   wgray_s1_q, wgray_s2_q;
    logic [ADDR_W:0]   rd_level_q, rd_level_d;
    logic              empty_q, empty_d, ae_q, ae_d, udf_q, rd_acc;
    logic [DATA_W-1:0] data_q;
    logic              valid_q;

    always_comb begin
        wr_acc     = bus.data_1_en & ~full_q & ~rst_w;
        wbin_d     = wbin_q + {{ADDR_W{1'b0}}, wr_acc};
        wgray_d    = bin2gray(wbin_d);
        // Full when the writer is exactly one lap ahead: top two Gray bits differ.
        full_d     = (wgray_d == {~rgray_s2_q[ADDR_W:ADDR_W-1], rgray_s2_q[ADDR_W-2:0]});
        wr_level_d = wbin_d - gray2bin(rgray_s2_q);
        af_d       = (wr_level_d >= AF_THR);
    end

    always_ff @(posedge clk_1 or posedge rst_w) begin
        if (rst_w) begin
            wbin_q     <= '0;
            wgray_q    <= '0;
            rgray_s1_q <= '0;
            rgray_s2_q <= '0;
            full_q     <= 1'b0;
            wr_level_q <= '0;
            af_q       <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            wbin_q     <= wbin_d;
            wgray_q    <= wgray_d;
            rgray_s1_q <= rgray_q;
            rgray_s2_q <= rgray_s1_q;
            full_q     <= full_d;
            wr_level_q <= wr_level_d;
            af_q       <= af_d;
            if (bus.data_1_en && full_q) ovf_q <= 1'b1;
        end
    end

    always_ff @(posedge clk_1) begin
        if (wr_acc) mem[wbin_q[ADDR_W-1:0]] <= bus.data_1;
    end

    always_comb begin
        rd_acc     = bus.data_2_rd & ~empty_q & ~rst_r;
        rbin_d     = rbin_q + {{ADDR_W{1'b0}}, rd_acc};
        rgray_d    = bin2gray(rbin_d);
        empty_d    = (rgray_d == wgray_s2_q);
        rd_level_d = gray2bin(wgray_s2_q) - rbin_d;
        ae_d       = (rd_level_d <= AE_THR);
    end

    always_ff @(posedge clk_2 or posedge rst_r) begin
        if (rst_r) begin
            rbin_q     <= '0;
            rgray_q    <= '0;
            wgray_s1_q <= '0;
            wgray_s2_q <= '0;
            empty_q    <= 1'b1;
            rd_level_q <= '0;
            ae_q       <= 1'b1;
            udf_q      <= 1'b0;
            data_q     <= '0;
            valid_q    <= 1'b0;
        end else begin
            rbin_q     <= rbin_d;
            rgray_q    <= rgray_d;
            wgray_s1_q <= wgray_q;
            wgray_s2_q <= wgray_s1_q;
            empty_q    <= empty_d;
            rd_level_q <= rd_level_d;
            ae_q       <= ae_d;
            valid_q    <= rd_acc;
            if (rd_acc) data_q <= mem[rbin_q[ADDR_W-1:0]];
            if (bus.data_2_rd && empty_q) udf_q <= 1'b1;
        end
    end

    assign bus.buffer_full  = full_q;
    assign bus.almost_full  = af_q;
    assign bus.wr_level     = wr_level_q;
    assign bus.overflow     = ovf_q;
    assign bus.data_2       = data_q;
    assign bus.data_2_valid = valid_q;
    assign bus.buffer_empty = empty_q;
    assign bus.almost_empty = ae_q;
    assign bus.rd_level     = rd_level_q;
    assign bus.underflow    = udf_q;
endmodule
